commit_chk: RTL and testbench

COMMIT_CHK -- requirements
Module: commit_chk

---
 rtl/commit_chk_if.sv | 36 +++
 rtl/commit_chk.sv | 123 ++++++++++++
 tb/tb_commit_chk.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_chk_if.sv
// Commit stream bundle: DUT writeback commits plus the reference-model commit handshake.
interface commit_chk_if #(
   parameter int PC_WD      = 64,
   parameter int INST_WD    = 32,
   parameter int RF_ADDR_WD = 5,
   parameter int RF_DATA_WD = 64
);
   logic                  ws_valid;
   logic [PC_WD-1:0]      debug_wb_pc;
   logic [INST_WD-1:0]    debug_wb_inst;
   logic                  debug_wb_rf_wen;
   logic [RF_ADDR_WD-1:0] debug_wb_rf_wnum;
   logic [RF_DATA_WD-1:0] debug_wb_rf_wdata;
   logic                  stop;

   logic                  ref_valid;
   logic                  ref_ready;
   logic [PC_WD-1:0]      ref_pc;
   logic                  ref_rf_wen;
   logic [RF_ADDR_WD-1:0] ref_rf_wnum;
   logic [RF_DATA_WD-1:0] ref_rf_wdata;

   modport master (
      output ws_valid, debug_wb_pc, debug_wb_inst, debug_wb_rf_wen,
             debug_wb_rf_wnum, debug_wb_rf_wdata, stop,
             ref_valid, ref_pc, ref_rf_wen, ref_rf_wnum, ref_rf_wdata,
      input  ref_ready
   );

   modport slave (
      input  ws_valid, debug_wb_pc, debug_wb_inst, debug_wb_rf_wen,
             debug_wb_rf_wnum, debug_wb_rf_wdata, stop,
             ref_valid, ref_pc, ref_rf_wen, ref_rf_wnum, ref_rf_wdata,
      output ref_ready
   );
endinterface

// File: rtl/commit_chk.sv
// Commit checker: buffers DUT commits in a FIFO and compares each against the reference stream.
//   state | meaning
//   RUN   | accepting commits and comparing against reference
//   HALT  | halting instruction matched; everything frozen until reset
//   ERROR | mismatch or FIFO overflow seen; everything frozen until reset
module commit_chk #(
   parameter int PC_WD      = 64,
   parameter int INST_WD    = 32,
   parameter int RF_ADDR_WD = 5,
   parameter int RF_DATA_WD = 64,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   commit_chk_if.slave              bus,
   output logic [1:0]               chk_state,
   output logic                     mismatch,
   output logic                     overflow,
   output logic                     halt_done,
   output logic [PC_WD-1:0]         err_pc,
   output logic [INST_WD-1:0]       err_inst,
   output logic [63:0]              commit_cnt,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, ERROR = 2'd2} state_t;

   typedef struct packed {
      logic [PC_WD-1:0]      pc;
      logic [INST_WD-1:0]    inst;
      logic                  wen;
      logic [RF_ADDR_WD-1:0] wnum;
      logic [RF_DATA_WD-1:0] wdata;
      logic                  stop;
   } entry_t;

   state_t        state_q, state_d;
   entry_t        mem [DEPTH];
   entry_t        head, wr_entry;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt_q;
   logic          running, push_req, push, pop, ovf, mis, match;
   logic          head_eff, ref_eff;

   assign running       = (state_q == RUN);
   assign bus.ref_ready = running && (cnt_q != '0) && bus.ref_valid && !reset;
   assign pop           = bus.ref_ready;
   assign push_req      = running && bus.ws_valid && !reset;
   assign ovf           = push_req && (cnt_q == FULL) && !pop;
   assign push          = push_req && !ovf;
   assign head          = mem[rd_ptr];

   always_comb begin
      wr_entry.pc    = bus.debug_wb_pc;
      wr_entry.inst  = bus.debug_wb_inst;
      wr_entry.wen   = bus.debug_wb_rf_wen;
      wr_entry.wnum  = bus.debug_wb_rf_wnum;
      wr_entry.wdata = bus.debug_wb_rf_wdata;
      wr_entry.stop  = bus.stop;
   end

   // Writes to x0 are architecturally invisible, so they count as "no write".
   assign head_eff = head.wen && (head.wnum != '0);
   assign ref_eff  = bus.ref_rf_wen && (bus.ref_rf_wnum != '0);
   assign match    = (head.pc == bus.ref_pc) && (head_eff == ref_eff) &&
                     (!head_eff || ((head.wnum == bus.ref_rf_wnum) &&
                                    (head.wdata == bus.ref_rf_wdata)));
   assign mis      = pop && !match;

   always_comb begin
      state_d = state_q;
      if (running) begin
         if (mis || ovf)
            state_d = ERROR;
         else if (pop && head.stop)
            state_d = HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt_q      <= '0;
         mismatch   <= 1'b0;
         overflow   <= 1'b0;
         halt_done  <= 1'b0;
         err_pc     <= '0;
         err_inst   <= '0;
         commit_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            cnt_q <= cnt_q + (AW+1)'(1);
         else if (pop && !push)
            cnt_q <= cnt_q - (AW+1)'(1);
         if (pop && match) commit_cnt <= commit_cnt + 64'd1;
         if (pop && match && head.stop) halt_done <= 1'b1;
         if (mis) mismatch <= 1'b1;
         if (ovf) overflow <= 1'b1;
         // A mismatching head is the more useful diagnostic than a dropped commit.
         if (mis) begin
            err_pc   <= head.pc;
            err_inst <= head.inst;
         end else if (ovf) begin
            err_pc   <= bus.debug_wb_pc;
            err_inst <= bus.debug_wb_inst;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign chk_state = state_q;
   assign fifo_cnt  = cnt_q;
endmodule

// File: tb/tb_commit_chk.sv
// Directed bench for commit_chk with a queue-based reference model checked every cycle.
module tb_commit_chk;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  chk_state;
   logic        mismatch, overflow, halt_done;
   logic [63:0] err_pc;
   logic [31:0] err_inst;
   logic [63:0] commit_cnt;
   logic [3:0]  fifo_cnt;

   always #5 clk = ~clk;

   commit_chk_if #(.PC_WD(64), .INST_WD(32), .RF_ADDR_WD(5), .RF_DATA_WD(64)) bus ();

   commit_chk #(.PC_WD(64), .INST_WD(32), .RF_ADDR_WD(5), .RF_DATA_WD(64), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .chk_state(chk_state), .mismatch(mismatch), .overflow(overflow),
      .halt_done(halt_done), .err_pc(err_pc), .err_inst(err_inst),
      .commit_cnt(commit_cnt), .fifo_cnt(fifo_cnt)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        wen;
      logic [4:0]  wnum;
      logic [63:0] wdata;
      logic        stop;
   } ent_t;

   ent_t        q[$];
   ent_t        h;
   int          m_state;
   bit          m_mis, m_ovf, m_halt, started;
   logic [63:0] m_err_pc, m_cnt;
   logic [31:0] m_err_inst;
   bit          rr, full;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_match(ent_t e);
      bit de, re;
      de = e.wen && (e.wnum != 0);
      re = bus.ref_rf_wen && (bus.ref_rf_wnum != 0);
      if (e.pc != bus.ref_pc) return 1'b0;
      if (de != re) return 1'b0;
      if (de && ((e.wnum != bus.ref_rf_wnum) || (e.wdata != bus.ref_rf_wdata))) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_state = 0; m_mis = 0; m_ovf = 0; m_halt = 0;
         m_err_pc = 0; m_err_inst = 0; m_cnt = 0;
         started = 1;
      end else if (m_state == 0) begin
         rr   = (q.size() != 0) && bus.ref_valid;
         full = (q.size() == DEPTH) && !rr;
         if (rr) begin
            h = q.pop_front();
            if (ref_match(h)) begin
               m_cnt = m_cnt + 1;
               if (h.stop) begin m_state = 1; m_halt = 1; end
            end else begin
               m_state = 2; m_mis = 1; m_err_pc = h.pc; m_err_inst = h.inst;
            end
         end
         if (bus.ws_valid) begin
            if (full) begin
               m_state = 2; m_ovf = 1;
               if (!m_mis) begin m_err_pc = bus.debug_wb_pc; m_err_inst = bus.debug_wb_inst; end
            end else begin
               q.push_back('{bus.debug_wb_pc, bus.debug_wb_inst, bus.debug_wb_rf_wen,
                             bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata, bus.stop});
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("chk_state",  chk_state,  m_state);
         check("mismatch",   mismatch,   m_mis);
         check("overflow",   overflow,   m_ovf);
         check("halt_done",  halt_done,  m_halt);
         check("err_pc",     err_pc,     m_err_pc);
         check("err_inst",   err_inst,   m_err_inst);
         check("commit_cnt", commit_cnt, m_cnt);
         check("fifo_cnt",   fifo_cnt,   q.size());
         check("ref_ready",  bus.ref_ready,
               !reset && m_state == 0 && q.size() != 0 && bus.ref_valid);
      end
   end

   task automatic set_ws(bit v, logic [63:0] pc, logic [31:0] inst, bit wen,
                         logic [4:0] wnum, logic [63:0] wdata, bit stop);
      bus.ws_valid = v; bus.debug_wb_pc = pc; bus.debug_wb_inst = inst;
      bus.debug_wb_rf_wen = wen; bus.debug_wb_rf_wnum = wnum;
      bus.debug_wb_rf_wdata = wdata; bus.stop = stop;
   endtask

   task automatic set_ref(bit v, logic [63:0] pc, bit wen, logic [4:0] wnum, logic [63:0] wdata);
      bus.ref_valid = v; bus.ref_pc = pc; bus.ref_rf_wen = wen;
      bus.ref_rf_wnum = wnum; bus.ref_rf_wdata = wdata;
   endtask

   task automatic idle();
      set_ws(0, 0, 0, 0, 0, 0, 0);
      set_ref(0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick(); tick();
      reset = 1'b0;

      // three commits, reference trailing by two cycles
      for (int i = 0; i < 5; i++) begin
         if (i < 3) set_ws(1, 64'h8000_0000 + 64'(4*i), 32'h13, 1, 5'(i+1), 64'h100 + 64'(i), 0);
         else       set_ws(0, 0, 0, 0, 0, 0, 0);
         if (i >= 2) set_ref(1, 64'h8000_0000 + 64'(4*(i-2)), 1, 5'(i-1), 64'h100 + 64'(i-2));
         else        set_ref(0, 0, 0, 0, 0);
         tick();
      end
      idle();
      sample();
      check("s1_commit_cnt", commit_cnt, 64'd3);
      check("s1_fifo_cnt",   fifo_cnt,   64'd0);
      check("s1_state",      chk_state,  64'd0);
      #1;

      // x0 write on DUT side equals no write on reference side
      set_ws(1, 64'h8000_0020, 32'h0, 1, 5'd0, 64'h1234, 0);
      tick();
      set_ws(0, 0, 0, 0, 0, 0, 0);
      set_ref(1, 64'h8000_0020, 0, 5'd0, 64'h0);
      tick();
      idle();
      sample();
      check("s2_commit_cnt", commit_cnt, 64'd4);
      check("s2_mismatch",   mismatch,   64'd0);
      #1;

      // wdata mismatch at head with four commits queued
      for (int i = 0; i < 5; i++) begin
         set_ws(1, 64'h8000_0010 + 64'(4*i), 32'hDEAD_0000 + 32'(i), 1,
                (i == 0) ? 5'd10 : 5'd1, (i == 0) ? 64'h6 : 64'h0, 0);
         if (i == 4) set_ref(1, 64'h8000_0010, 1, 5'd10, 64'h5);
         else        set_ref(0, 0, 0, 0, 0);
         tick();
      end
      idle();
      sample();
      check("s3_mismatch",   mismatch,   64'd1);
      check("s3_state",      chk_state,  64'd2);
      check("s3_err_pc",     err_pc,     64'h8000_0010);
      check("s3_err_inst",   err_inst,   64'hDEAD_0000);
      check("s3_fifo_cnt",   fifo_cnt,   64'd4);
      check("s3_commit_cnt", commit_cnt, 64'd4);
      #1;
      set_ws(1, 64'h8000_0040, 32'h1, 1, 5'd2, 64'h7, 0);
      set_ref(1, 64'h8000_0014, 1, 5'd1, 64'h0);
      tick(); tick();
      sample();
      check("s3_ref_ready_held", bus.ref_ready, 64'd0);
      check("s3_fifo_frozen",    fifo_cnt,      64'd4);
      #1;
      reset = 1'b1;
      tick();
      sample();
      check("rst_ref_ready",  bus.ref_ready, 64'd0);
      check("rst_state",      chk_state,     64'd0);
      check("rst_mismatch",   mismatch,      64'd0);
      check("rst_fifo_cnt",   fifo_cnt,      64'd0);
      check("rst_err_pc",     err_pc,        64'd0);
      check("rst_commit_cnt", commit_cnt,    64'd0);
      #1;
      reset = 1'b0;
      idle();

      // DEPTH+1 pushes with no reference
      for (int i = 0; i < DEPTH + 1; i++) begin
         set_ws(1, 64'h9000_0000 + 64'(4*i), 32'h9000 + 32'(i), 1, 5'd1, 64'(i), 0);
         tick();
      end
      idle();
      sample();
      check("s4_overflow", overflow,  64'd1);
      check("s4_mismatch", mismatch,  64'd0);
      check("s4_state",    chk_state, 64'd2);
      check("s4_err_pc",   err_pc,    64'h9000_0020);
      check("s4_err_inst", err_inst,  64'h9008);
      check("s4_fifo_cnt", fifo_cnt,  64'd8);
      #1;
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // push and pop together while full, then drain
      for (int i = 0; i < DEPTH + 1; i++) begin
         set_ws(1, 64'hA000_0000 + 64'(4*i), 32'hA0 + 32'(i), 1, 5'(i+1), 64'hA0 + 64'(i), 0);
         if (i == DEPTH) set_ref(1, 64'hA000_0000, 1, 5'd1, 64'hA0);
         else            set_ref(0, 0, 0, 0, 0);
         tick();
      end
      idle();
      sample();
      check("s5_fifo_full",  fifo_cnt,   64'd8);
      check("s5_overflow",   overflow,   64'd0);
      check("s5_commit_cnt", commit_cnt, 64'd1);
      #1;
      for (int k = 1; k <= DEPTH; k++) begin
         set_ref(1, 64'hA000_0000 + 64'(4*k), 1, 5'(k+1), 64'hA0 + 64'(k));
         tick();
      end
      idle();
      sample();
      check("s5_drain_cnt",  commit_cnt, 64'd9);
      check("s5_drain_fifo", fifo_cnt,   64'd0);
      #1;

      // halting instruction
      set_ws(1, 64'h8000_0100, 32'h0010_0073, 0, 5'd0, 64'h0, 1);
      tick();
      set_ws(0, 0, 0, 0, 0, 0, 0);
      set_ref(1, 64'h8000_0100, 0, 5'd0, 64'h0);
      tick();
      idle();
      sample();
      check("s6_halt_done",  halt_done,  64'd1);
      check("s6_state",      chk_state,  64'd1);
      check("s6_commit_cnt", commit_cnt, 64'd10);
      #1;
      for (int i = 0; i < 3; i++) begin
         set_ws(1, 64'h8000_0104, 32'h13, 1, 5'd3, 64'h9, 0);
         set_ref(1, 64'h8000_0104, 1, 5'd3, 64'h9);
         tick();
      end
      idle();
      sample();
      check("s6_cnt_frozen",  commit_cnt, 64'd10);
      check("s6_fifo_frozen", fifo_cnt,   64'd0);
      check("s6_state_held",  chk_state,  64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
